// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Freeze vectors are {wb, mem, ex, id, if, pc}, bit0 = pc.
package pipe_ctrl_pkg;

   typedef logic reset_status_t;
   localparam reset_status_t RST_ENABLE = 1'b0;

   typedef logic [5:0] stall_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ID   = 2'd1,
      SRC_EX   = 2'd2,
      SRC_MEM  = 2'd3
   } stall_src_t;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_STALL_ID,
      ST_STALL_EX,
      ST_STALL_MEM,
      ST_TIMEOUT
   } pipe_ctrl_state_t;

   localparam stall_t STALL_NONE     = 6'b000000;
   localparam stall_t STALL_FROM_ID  = 6'b000111;
   localparam stall_t STALL_FROM_EX  = 6'b001111;
   localparam stall_t STALL_FROM_MEM = 6'b011111;

   function automatic pipe_ctrl_state_t src_state(stall_src_t s);
      case (s)
         SRC_ID:  return ST_STALL_ID;
         SRC_EX:  return ST_STALL_EX;
         SRC_MEM: return ST_STALL_MEM;
         default: return ST_RUN;
      endcase
   endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (en && (q != '1))
         q <= q + W'(1);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall controller: priority-resolves ID/EX/MEM stall requests into a freeze
// vector and tracks stall episodes with a watchdog and a cycle counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_STALL = 64,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_from_id,
   input  logic             stallreq_from_ex,
   input  logic             stallreq_from_mem,
   output logic [5:0]       stall,
   output logic [1:0]       stall_cause,
   output logic             stall_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int LEN_W = $clog2(MAX_STALL + 1);

   stall_src_t       cause;
   pipe_ctrl_state_t state_q, state_d;
   logic [LEN_W-1:0] stall_len;
   logic             len_en, len_clr;

   always_comb begin
      cause = SRC_NONE;
      stall = STALL_NONE;
      if (stallreq_from_mem) begin
         cause = SRC_MEM;
         stall = STALL_FROM_MEM;
      end else if (stallreq_from_ex) begin
         cause = SRC_EX;
         stall = STALL_FROM_EX;
      end else if (stallreq_from_id) begin
         cause = SRC_ID;
         stall = STALL_FROM_ID;
      end
   end

   assign stall_cause = cause;

   // An episode continues only while the same cause persists; anything else
   // restarts the length. The watchdog fires on the edge where the length
   // would reach MAX_STALL-1, i.e. after MAX_STALL requested cycles.
   always_comb begin
      state_d = state_q;
      len_en  = 1'b0;
      len_clr = 1'b0;
      if (state_q == ST_TIMEOUT) begin
         len_clr = 1'b1;
         if (cause == SRC_NONE)
            state_d = ST_RUN;
      end else begin
         state_d = src_state(cause);
         if ((cause != SRC_NONE) && (src_state(cause) == state_q)) begin
            len_en = 1'b1;
            if (int'(stall_len) + 1 == MAX_STALL - 1)
               state_d = ST_TIMEOUT;
         end else begin
            len_clr = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE)
         state_q <= ST_RUN;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE)
         stall_timeout <= 1'b0;
      else if (state_d == ST_TIMEOUT)
         stall_timeout <= 1'b1;
   end

   sat_counter #(.W(LEN_W)) u_len (
      .clk (clk),
      .rst (rst),
      .en  (len_en),
      .clr (len_clr),
      .q   (stall_len)
   );

   sat_counter #(.W(CNT_W)) u_cycles (
      .clk (clk),
      .rst (rst),
      .en  (stall[0]),
      .clr (1'b0),
      .q   (stall_cycles)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance plus a short-watchdog,
// narrow-counter instance driven by the same requests.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk, rst;
   logic id, ex, mem;

   logic [5:0]  stall_a, stall_b;
   logic [1:0]  cause_a, cause_b;
   logic        to_a, to_b;
   logic [31:0] cyc_a;
   logic [3:0]  cyc_b;

   int checks   = 0;
   int failures = 0;

   pipe_ctrl dut_a (
      .clk               (clk),
      .rst               (rst),
      .stallreq_from_id  (id),
      .stallreq_from_ex  (ex),
      .stallreq_from_mem (mem),
      .stall             (stall_a),
      .stall_cause       (cause_a),
      .stall_timeout     (to_a),
      .stall_cycles      (cyc_a)
   );

   pipe_ctrl #(.MAX_STALL(8), .CNT_W(4)) dut_b (
      .clk               (clk),
      .rst               (rst),
      .stallreq_from_id  (id),
      .stallreq_from_ex  (ex),
      .stallreq_from_mem (mem),
      .stall             (stall_b),
      .stall_cause       (cause_b),
      .stall_timeout     (to_b),
      .stall_cycles      (cyc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse placed well away from the clock edge.
   task automatic rst_pulse();
      tick();
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1; id = 1'b0; ex = 1'b0; mem = 1'b0;
      #2 rst = 1'b0;
      tick(); tick();
      chk("rst_stall",  64'(stall_a), 64'(6'b000000));
      chk("rst_cause",  64'(cause_a), 64'(0));
      chk("rst_to",     64'(to_a), 64'(0));
      chk("rst_cycles", 64'(cyc_a), 64'(0));
      chk("rst_state",  64'(dut_a.state_q), 64'(ST_RUN));
      chk("rst_len",    64'(dut_a.stall_len), 64'(0));

      // combinational path is live during reset, registers stay cleared
      id = 1'b1; #1;
      chk("rst_comb_stall", 64'(stall_a), 64'(6'b000111));
      tick();
      chk("rst_hold_cycles", 64'(cyc_a), 64'(0));
      id = 1'b0;
      rst = 1'b1;
      tick();

      // single-cycle ID pulse
      id = 1'b1; #1;
      chk("id_stall", 64'(stall_a), 64'(6'b000111));
      chk("id_cause", 64'(cause_a), 64'(1));
      tick();
      id = 1'b0; #1;
      chk("id_cycles", 64'(cyc_a), 64'(1));
      chk("id_state1", 64'(dut_a.state_q), 64'(ST_STALL_ID));
      chk("id_stall_off", 64'(stall_a), 64'(0));
      tick();
      chk("id_state2", 64'(dut_a.state_q), 64'(ST_RUN));

      // priority: all high then drop MEM
      id = 1'b1; ex = 1'b1; mem = 1'b1; #1;
      chk("all_stall", 64'(stall_a), 64'(6'b011111));
      chk("all_cause", 64'(cause_a), 64'(3));
      mem = 1'b0; #1;
      chk("idex_stall", 64'(stall_a), 64'(6'b001111));
      chk("idex_cause", 64'(cause_a), 64'(2));
      id = 1'b0; ex = 1'b0; #1;
      chk("none_stall", 64'(stall_a), 64'(0));

      // EX 10 cycles then MEM 5 cycles, no gap
      rst_pulse();
      ex = 1'b1;
      repeat (10) tick();
      chk("ex10_len",   64'(dut_a.stall_len), 64'(9));
      chk("ex10_state", 64'(dut_a.state_q), 64'(ST_STALL_EX));
      ex = 1'b0; mem = 1'b1;
      tick();
      chk("sw_len",   64'(dut_a.stall_len), 64'(0));
      chk("sw_state", 64'(dut_a.state_q), 64'(ST_STALL_MEM));
      repeat (4) tick();
      chk("mem5_len", 64'(dut_a.stall_len), 64'(4));
      mem = 1'b0;
      chk("exmem_cycles", 64'(cyc_a), 64'(15));
      chk("exmem_to",     64'(to_a), 64'(0));
      tick();
      chk("exmem_state", 64'(dut_a.state_q), 64'(ST_RUN));
      chk("exmem_len",   64'(dut_a.stall_len), 64'(0));

      // watchdog on MAX_STALL=8 instance
      rst_pulse();
      ex = 1'b1;
      repeat (7) tick();
      chk("wd7_to", 64'(to_b), 64'(0));
      tick();
      chk("wd8_to",    64'(to_b), 64'(1));
      chk("wd8_state", 64'(dut_b.state_q), 64'(ST_TIMEOUT));
      chk("wd8_stall", 64'(stall_b), 64'(6'b001111));
      chk("wd8_to_a",  64'(to_a), 64'(0));
      tick();
      chk("wd9_state", 64'(dut_b.state_q), 64'(ST_TIMEOUT));
      ex = 1'b0; #1;
      chk("wd_drop_stall", 64'(stall_b), 64'(0));
      tick();
      chk("wd_run_state", 64'(dut_b.state_q), 64'(ST_RUN));
      chk("wd_sticky",    64'(to_b), 64'(1));
      chk("wd_cycles_b",  64'(cyc_b), 64'(9));

      // saturation of the 4-bit counter
      rst_pulse();
      chk("sat_to_clr", 64'(to_b), 64'(0));
      chk("sat_cyc0",   64'(cyc_b), 64'(0));
      mem = 1'b1;
      repeat (20) tick();
      chk("sat_cyc_b", 64'(cyc_b), 64'(15));
      chk("sat_cyc_a", 64'(cyc_a), 64'(20));

      // async reset in the middle of an EX stall
      mem = 1'b0; ex = 1'b1;
      repeat (3) tick();
      chk("pre_state", 64'(dut_a.state_q), 64'(ST_STALL_EX));
      #2 rst = 1'b0;
      #1;
      chk("ar_state",  64'(dut_a.state_q), 64'(ST_RUN));
      chk("ar_len",    64'(dut_a.stall_len), 64'(0));
      chk("ar_cycles", 64'(cyc_a), 64'(0));
      chk("ar_to_b",   64'(to_b), 64'(0));
      chk("ar_stall",  64'(stall_a), 64'(6'b001111));
      chk("ar_cause",  64'(cause_a), 64'(2));
      #1 rst = 1'b1;
      tick();
      chk("ar_rel_state",  64'(dut_a.state_q), 64'(ST_STALL_EX));
      chk("ar_rel_len",    64'(dut_a.stall_len), 64'(0));
      chk("ar_rel_cycles", 64'(cyc_a), 64'(1));
      ex = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
